// File: rtl/pipe_pkg.sv
// Shared encodings for the EX stage: ALU op codes, mul/div op codes, mul/div FSM states.
// Optional build macro PIPE_FAST_MULT_EN is consumed by muldiv_seq.
package pipe_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

  // Magnitude of v when it is a signed operand, otherwise v unchanged.
  function automatic logic [31:0] abs_if(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine with architectural HI/LO; FSM state exported on o_state.
// PIPE_FAST_MULT_EN: mult/multu finish through a combinational multiplier (IDLE -> FIX).
module muldiv_seq import pipe_pkg::*; #(
  parameter int MD_ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo,
  output md_state_t   o_state
);

  localparam int CW = $clog2(MD_ITER + 1);
  localparam logic [CW-1:0] LAST = CW'(MD_ITER - 1);

  md_state_t   r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_dvsr, r_a_raw, r_hi, r_lo;
  logic        r_is_div, r_neg_res, r_neg_rem, r_div0;

  logic        w_signed, w_is_div;
  logic [31:0] w_a_abs, w_b_abs;
  logic [32:0] w_madd;
  logic [63:0] w_mul_next, w_div_next, w_prod;
  logic [31:0] w_part, w_sub, w_fix_hi, w_fix_lo;
  logic        w_ge;

  assign w_signed = (i_op == MD_MULT) || (i_op == MD_DIV);
  assign w_is_div = (i_op == MD_DIV) || (i_op == MD_DIVU);
  assign w_a_abs  = abs_if(i_a, w_signed);
  assign w_b_abs  = abs_if(i_b, w_signed);

  // Multiply: acc = {partial, multiplier}; add multiplicand into the top half, shift right.
  assign w_madd     = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_dvsr} : 33'd0);
  assign w_mul_next = {w_madd, r_acc[31:1]};

  // Divide: acc = {remainder, dividend}; acc[63] set means the shifted remainder exceeds 32 bits.
  assign w_part     = {r_acc[62:32], r_acc[31]};
  assign w_ge       = r_acc[63] | (w_part >= r_dvsr);
  assign w_sub      = w_part - r_dvsr;
  assign w_div_next = {(w_ge ? w_sub : w_part), r_acc[30:0], w_ge};

  assign w_prod = r_neg_res ? (~r_acc + 64'd1) : r_acc;

  always_comb begin
    w_fix_hi = '0;
    w_fix_lo = '0;
    if (r_div0) begin
      w_fix_hi = r_a_raw;
      w_fix_lo = '1;
    end else if (r_is_div) begin
      w_fix_lo = r_neg_res ? (~r_acc[31:0] + 32'd1) : r_acc[31:0];
      w_fix_hi = r_neg_rem ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];
    end else begin
      w_fix_hi = w_prod[63:32];
      w_fix_lo = w_prod[31:0];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      MD_IDLE: begin
        if (i_start) begin
`ifdef PIPE_FAST_MULT_EN
          w_next = w_is_div ? MD_BUSY : MD_FIX;
`else
          w_next = MD_BUSY;
`endif
        end
      end
      MD_BUSY: if (r_cnt == LAST) w_next = MD_FIX;
      MD_FIX:  w_next = MD_IDLE;
      default: w_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= MD_IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_dvsr    <= '0;
      r_a_raw   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (i_start) begin
            r_cnt     <= '0;
            r_is_div  <= w_is_div;
            r_neg_res <= w_signed & (i_a[31] ^ i_b[31]);
            r_neg_rem <= w_signed & i_a[31];
            r_div0    <= w_is_div & (i_b == 32'd0);
            r_a_raw   <= i_a;
            r_dvsr    <= w_is_div ? w_b_abs : w_a_abs;
`ifdef PIPE_FAST_MULT_EN
            r_acc     <= w_is_div ? {32'd0, w_a_abs} : ({32'd0, w_a_abs} * {32'd0, w_b_abs});
`else
            r_acc     <= {32'd0, (w_is_div ? w_a_abs : w_b_abs)};
`endif
          end
        end
        MD_BUSY: begin
          r_cnt <= r_cnt + CW'(1);
          r_acc <= r_is_div ? w_div_next : w_mul_next;
        end
        MD_FIX: begin
          r_cnt <= '0;
          r_hi  <= w_fix_hi;
          r_lo  <= w_fix_lo;
        end
        default: ;
      endcase
    end
  end

  assign o_hi    = r_hi;
  assign o_lo    = r_lo;
  assign o_state = r_state;

endmodule

// File: rtl/pipe_exe_muldiv.sv
// EX stage: combinational ALU, HI/LO read mux and mul/div hazard stall around muldiv_seq.
// Build macro PIPE_FAST_MULT_EN selects the single-cycle multiplier inside muldiv_seq.
module pipe_exe_muldiv import pipe_pkg::*; #(
  parameter int MD_ITER = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  ealuc,
  input  logic [31:0] ea,
  input  logic [31:0] eb,
  input  logic [31:0] eimm,
  input  logic [4:0]  esa,
  input  logic        ealuimm,
  input  logic        eshift,
  input  logic        emd_start,
  input  logic [1:0]  emd_op,
  input  logic        emfhi,
  input  logic        emflo,
  input  logic        ecancel,
  output logic [31:0] ealu,
  output logic        md_stall,
  output logic        md_busy
);

  logic [31:0] w_b, w_alu, w_hi, w_lo;
  logic [4:0]  w_sa;
  logic        w_start;
  md_state_t   w_state;

  assign w_b  = ealuimm ? eimm : eb;
  assign w_sa = eshift ? esa : ea[4:0];

  always_comb begin
    w_alu = '0;
    case (ealuc)
      ALU_ADD: w_alu = ea + w_b;
      ALU_SUB: w_alu = ea - w_b;
      ALU_AND: w_alu = ea & w_b;
      ALU_OR:  w_alu = ea | w_b;
      ALU_XOR: w_alu = ea ^ w_b;
      ALU_LUI: w_alu = {w_b[15:0], 16'd0};
      ALU_SLL: w_alu = w_b << w_sa;
      ALU_SRL: w_alu = w_b >> w_sa;
      ALU_SRA: w_alu = $signed(w_b) >>> w_sa;
      default: w_alu = '0;
    endcase
  end

  assign ealu = emfhi ? w_hi : (emflo ? w_lo : w_alu);

  // Only instructions touching HI/LO or the engine wait; everything else flows past.
  assign md_busy  = (w_state != MD_IDLE);
  assign md_stall = md_busy & (emd_start | emfhi | emflo);
  assign w_start  = emd_start & ~ecancel & ~md_stall;

  muldiv_seq #(.MD_ITER(MD_ITER)) u_muldiv (
    .clock   (clock),
    .reset   (reset),
    .i_start (w_start),
    .i_op    (emd_op),
    .i_a     (ea),
    .i_b     (eb),
    .o_hi    (w_hi),
    .o_lo    (w_lo),
    .o_state (w_state)
  );

endmodule

// File: tb/tb_pipe_exe_muldiv.sv
// Scoreboard bench for pipe_exe_muldiv: directed spec cases plus randomized ALU/mul/div/mf traffic.
// Honours PIPE_FAST_MULT_EN for the expected multiply latency.
module tb_pipe_exe_muldiv;

  localparam logic [3:0] A_ADD = 4'b0000, A_SUB = 4'b0100, A_AND = 4'b0001, A_OR = 4'b0101,
                         A_XOR = 4'b0010, A_LUI = 4'b0110, A_SLL = 4'b0011, A_SRL = 4'b0111,
                         A_SRA = 4'b1111;
  localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  ealuc;
  logic [31:0] ea, eb, eimm;
  logic [4:0]  esa;
  logic        ealuimm, eshift, emd_start, emfhi, emflo, ecancel;
  logic [1:0]  emd_op;
  logic [31:0] ealu;
  logic        md_stall, md_busy;

  logic        v_chk;
  logic        started = 1'b0;
  int          cyc = 0;
  int          busy_until = -1;
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [3:0]  alu_codes[9] = '{A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_LUI, A_SLL, A_SRL, A_SRA};

  pipe_exe_muldiv dut (
    .clock(clock), .reset(reset), .ealuc(ealuc), .ea(ea), .eb(eb), .eimm(eimm), .esa(esa),
    .ealuimm(ealuimm), .eshift(eshift), .emd_start(emd_start), .emd_op(emd_op),
    .emfhi(emfhi), .emflo(emflo), .ecancel(ecancel), .ealu(ealu), .md_stall(md_stall),
    .md_busy(md_busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d, required completion", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, b, input int s);
    case (op)
      A_ADD: return a + b;
      A_SUB: return a - b;
      A_AND: return a & b;
      A_OR:  return a | b;
      A_XOR: return a ^ b;
      A_LUI: return b * 32'd65536;
      A_SLL: return b << s;
      A_SRL: return b >> s;
      A_SRA: return b[31] ? ~((~b) >> s) : (b >> s);
      default: return 32'd0;
    endcase
  endfunction

  task automatic md_ref(input logic [1:0] op, input logic [31:0] a, b, output logic [31:0] hi, lo);
    longint p;
    logic [63:0] pu;
    int sa, sb;
    sa = a;
    sb = b;
    hi = '0;
    lo = '0;
    if (op == OP_MULT) begin
      p = longint'(sa) * longint'(sb);
      pu = p;
      hi = pu[63:32];
      lo = pu[31:0];
    end else if (op == OP_MULTU) begin
      pu = {32'd0, a} * {32'd0, b};
      hi = pu[63:32];
      lo = pu[31:0];
    end else if (b == 32'd0) begin
      lo = 32'hFFFF_FFFF;
      hi = a;
    end else if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      lo = 32'h8000_0000;
      hi = 32'd0;
    end else if (op == OP_DIV) begin
      lo = sa / sb;
      hi = sa % sb;
    end else begin
      lo = a / b;
      hi = a % b;
    end
  endtask

  function automatic int md_lat(input logic [1:0] op);
`ifdef PIPE_FAST_MULT_EN
    if (op == OP_MULT || op == OP_MULTU) return 1;
`endif
    return 33 + 0 * op;
  endfunction

  function automatic int exp_stall(input int c);
    return (busy_until >= c) ? (busy_until - c + 1) : 0;
  endfunction

  // ---------------- checks ----------------
  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, got, exp);
    end
  endtask

  // Monitor: busy timing every cycle, and result pop when a checked instruction leaves EX.
  always @(negedge clock) begin
    logic exp_busy;
    logic [31:0] e;
    string t;
    if (started) begin
      exp_busy = (cyc <= busy_until);
      n_checks++;
      if (md_busy !== exp_busy) begin
        n_errors++;
        $display("FAIL md_busy at cycle %0d: got %b, required %b", cyc, md_busy, exp_busy);
      end
      if (v_chk && !md_stall) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL ealu_unexpected at cycle %0d: got %h, required nothing queued", cyc, ealu);
        end else begin
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (ealu !== e) begin
            n_errors++;
            $display("FAIL ealu_%s at cycle %0d: got %h, required %h", t, cyc, ealu, e);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    ealuc = A_ADD; ea = '0; eb = '0; eimm = '0; esa = '0; ealuimm = 0; eshift = 0;
    emd_start = 0; emd_op = OP_MULT; emfhi = 0; emflo = 0; ecancel = 0; v_chk = 0;
  endtask

  // Holds the presented instruction until it is not stalled; returns the stall count.
  task automatic run_instr(output int stalls);
    logic st;
    stalls = 0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clock);
      st = md_stall;
      @(posedge clock);
      #1;
      if (!st) begin
        idle_inputs();
        return;
      end
      stalls++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL instr_timeout at cycle %0d: stalled %0d cycles, required < 200", cyc, stalls);
    idle_inputs();
  endtask

  task automatic do_nop();
    idle_inputs();
    @(posedge clock);
    #1;
  endtask

  task automatic do_alu(input logic [3:0] op, input logic [31:0] a, b, imm, input logic [4:0] sa,
                        input logic aluimm, shift, input logic use_exp, input logic [31:0] exp);
    int st;
    logic [31:0] bb;
    int s;
    ealuc = op; ea = a; eb = b; eimm = imm; esa = sa; ealuimm = aluimm; eshift = shift;
    bb = aluimm ? imm : b;
    s = shift ? int'(sa) : int'(a[4:0]);
    exp_q.push_back(use_exp ? exp : alu_ref(op, a, bb, s));
    tag_q.push_back("alu");
    v_chk = 1;
    run_instr(st);
    check_int("alu_stall", st, 0);
  endtask

  task automatic do_md(input logic [1:0] op, input logic [31:0] a, b, input logic cancel);
    int st, c0, es;
    logic [31:0] h, l;
    ea = a; eb = b; emd_op = op; emd_start = 1; ecancel = cancel; v_chk = 0;
    c0 = cyc;
    es = exp_stall(c0);
    run_instr(st);
    check_int("md_start_stall", st, es);
    if (!cancel) begin
      md_ref(op, a, b, h, l);
      m_hi = h;
      m_lo = l;
      busy_until = c0 + st + md_lat(op);
    end
  endtask

  task automatic do_mf(input logic hi, input logic use_exp, input logic [31:0] exp);
    int st, es;
    emfhi = hi; emflo = ~hi;
    exp_q.push_back(use_exp ? exp : (hi ? m_hi : m_lo));
    tag_q.push_back(hi ? "mfhi" : "mflo");
    v_chk = 1;
    es = exp_stall(cyc);
    run_instr(st);
    check_int(hi ? "mfhi_stall" : "mflo_stall", st, es);
  endtask

  task automatic reset_cycle();
    reset = 1;
    @(posedge clock);
    #1;
    reset = 0;
    m_hi = '0;
    m_lo = '0;
    busy_until = -1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      4: return 32'd0 - 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int k;
    idle_inputs();
    reset = 1;
    m_hi = '0;
    m_lo = '0;
    repeat (3) @(posedge clock);
    #1;
    reset = 0;
    started = 1;

    // Reset state of HI/LO
    do_mf(1'b1, 1'b1, 32'd0);
    do_mf(1'b0, 1'b1, 32'd0);

    // ALU directed
    do_alu(A_SRA, 32'h0, 32'h8000_0000, 32'h0, 5'd4, 1'b0, 1'b1, 1'b1, 32'hF800_0000);
    do_alu(A_SUB, 32'd5, 32'd7, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    do_alu(A_LUI, 32'h0, 32'h0, 32'h0000_1234, 5'd0, 1'b1, 1'b0, 1'b1, 32'h1234_0000);

    // mult -3*7, mflo presented at T+2
    do_md(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    do_nop();
    do_mf(1'b0, 1'b1, 32'hFFFF_FFEB);
    do_mf(1'b1, 1'b1, 32'hFFFF_FFFF);

    // Independent add at T+2 flows past an in-flight op
    do_md(OP_DIVU, 32'd100, 32'd7, 1'b0);
    do_nop();
    do_alu(A_ADD, 32'd40, 32'd2, 32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 32'd42);
    do_mf(1'b0, 1'b1, 32'd14);

    // Divide corner cases
    do_md(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    do_mf(1'b0, 1'b1, 32'hFFFF_FFFD);
    do_mf(1'b1, 1'b1, 32'hFFFF_FFFF);
    do_md(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0);
    do_mf(1'b0, 1'b1, 32'h0FFF_FFFF);
    do_mf(1'b1, 1'b1, 32'd15);
    do_md(OP_DIV, 32'd9, 32'd0, 1'b0);
    do_mf(1'b0, 1'b1, 32'hFFFF_FFFF);
    do_mf(1'b1, 1'b1, 32'd9);
    do_md(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_mf(1'b0, 1'b1, 32'h8000_0000);
    do_mf(1'b1, 1'b1, 32'd0);
    do_md(OP_MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_mf(1'b1, 1'b1, 32'd1);
    do_mf(1'b0, 1'b1, 32'hFFFF_FFFE);

    // Reset in the middle of a divide (cycle T+10)
    do_md(OP_DIV, 32'd1000, 32'd3, 1'b0);
    repeat (9) do_nop();
    reset_cycle();
    do_mf(1'b1, 1'b1, 32'd0);
    do_mf(1'b0, 1'b1, 32'd0);

    // Cancelled start is ignored
    do_md(OP_MULTU, 32'd6, 32'd7, 1'b1);
    do_nop();
    do_mf(1'b0, 1'b1, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) begin
        do_alu(alu_codes[$urandom_range(0, 8)], $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'b0, 32'd0);
      end else if (k < 7) begin
        do_md(2'($urandom_range(0, 3)), pick(), pick(), ($urandom_range(0, 7) == 0));
        if ($urandom_range(0, 1) == 1) do_mf(1'($urandom_range(0, 1)), 1'b0, 32'd0);
      end else if (k < 9) begin
        do_mf(1'($urandom_range(0, 1)), 1'b0, 32'd0);
      end else begin
        do_nop();
      end
    end
    do_mf(1'b1, 1'b0, 32'd0);
    do_mf(1'b0, 1'b0, 32'd0);
    repeat (2) do_nop();

    check_int("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
